// File: rtl/por_reset_sequencer.sv
// Turns a raw POR flag into NUM_CH active-low resets released one at a time, lowest bit first.
// porb_in reaches the FSM through two flops; every output is registered.
module por_reset_sequencer #(
  parameter int NUM_CH        = 4,
  parameter int HOLD_CYCLES   = 4,
  parameter int FILTER_CYCLES = 16,
  parameter int STAGE_CYCLES  = 8,
  parameter int CNT_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              porb_in,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rstb_ch,
  output logic              porb_l,
  output logic              por_l,
  output logic              seq_busy,
  output logic [1:0]        seq_state,
  output logic [7:0]        por_events
);

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    FILTER = 2'd1,
    STAGE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX    = 4'(NUM_CH - 1);

  logic              porb_m_q;
  logic              porb_s_q;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        idx_q;
  logic [NUM_CH-1:0] rstb_q;
  logic              porb_l_q;
  logic              por_l_q;
  logic              busy_q;
  logic [7:0]        events_q;
  logic              abort;

  // Only released states can be aborted; HOLD and FILTER already keep every channel in reset.
  assign abort = ((state_q == STAGE) || (state_q == DONE)) && (!porb_s_q || sw_rst_req);

  always_ff @(posedge clock) begin
    if (reset) begin
      porb_m_q <= 1'b0;
      porb_s_q <= 1'b0;
      state_q  <= HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      rstb_q   <= '0;
      porb_l_q <= 1'b0;
      por_l_q  <= 1'b1;
      busy_q   <= 1'b1;
      events_q <= '0;
    end else begin
      porb_m_q <= porb_in;
      porb_s_q <= porb_m_q;
      if (abort) begin
        state_q  <= HOLD;
        cnt_q    <= '0;
        idx_q    <= '0;
        rstb_q   <= '0;
        porb_l_q <= 1'b0;
        por_l_q  <= 1'b1;
        busy_q   <= 1'b1;
        if (events_q != 8'hFF) begin
          events_q <= events_q + 8'd1;
        end
      end else begin
        case (state_q)
          HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              cnt_q   <= '0;
              state_q <= FILTER;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          FILTER: begin
            if (!porb_s_q) begin
              cnt_q <= '0;
            end else if (cnt_q == FILTER_LAST) begin
              cnt_q  <= '0;
              idx_q  <= 4'd1;
              rstb_q <= NUM_CH'(1);
              if (NUM_CH == 1) begin
                state_q  <= DONE;
                porb_l_q <= 1'b1;
                por_l_q  <= 1'b0;
                busy_q   <= 1'b0;
              end else begin
                state_q <= STAGE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          STAGE: begin
            if (cnt_q == STAGE_LAST) begin
              cnt_q  <= '0;
              idx_q  <= idx_q + 4'd1;
              rstb_q <= rstb_q | (NUM_CH'(1) << idx_q);
              if (idx_q == LAST_IDX) begin
                state_q  <= DONE;
                porb_l_q <= 1'b1;
                por_l_q  <= 1'b0;
                busy_q   <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rstb_ch    = rstb_q;
  assign porb_l     = porb_l_q;
  assign por_l      = por_l_q;
  assign seq_busy   = busy_q;
  assign seq_state  = state_q;
  assign por_events = events_q;

endmodule

// File: doc/por_reset_sequencer.md
Name: por_reset_sequencer

Overview:
- Parametrised digital successor to the behavioural POR model. Takes the raw analog POR flag (porb_in, asynchronous, 3.3V-domain level-shifted by the SCL180 pad), synchronises and glitch-filters it, then releases NUM_CH active-low reset domains one at a time, in order.
- Adds a software re-reset request, a minimum assertion hold, a busy/state readout and a saturating reset-event counter.
- Sits between the POR/pad ring and the core reset tree: housekeeping, core, user project, etc.

Parameters:
- NUM_CH, 4: number of sequenced reset outputs, 1..8.
- HOLD_CYCLES, 4: minimum cycles all outputs stay asserted after any (re)entry to HOLD. Must be >= 2.
- FILTER_CYCLES, 16: consecutive synchronised-high cycles of porb_in required before channel 0 releases. Must be >= 1.
- STAGE_CYCLES, 8: cycles between successive channel releases. Must be >= 1.
- CNT_W, 16: width of the shared delay counter. Must hold max(HOLD_CYCLES, FILTER_CYCLES, STAGE_CYCLES).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- porb_in  in  1  raw POR flag, asynchronous, high = supply good
- sw_rst_req  in  1  single-cycle pulse that re-runs the sequence
- rstb_ch  out  NUM_CH  per-domain active-low resets; bit 0 released first
- porb_l  out  1  high once all channels are released
- por_l  out  1  always ~porb_l
- seq_busy  out  1  high in any state other than DONE
- seq_state  out  2  current state encoding
- por_events  out  8  saturating count of re-entries to HOLD

Behaviour:
- Reset is synchronous and active-high. While reset is high:
  - state=HOLD, cnt=0, idx=0, sync flops=0, rstb_ch=0, porb_l=0, por_l=1, seq_busy=1, por_events=0.
- Synchroniser: 2-flop chain, porb_in -> porb_s. Latency is 2 edges. No other logic samples porb_in.
- Outputs: all are registered, and none are combinational from inputs.
- States (seq_state encoding): HOLD=0, FILTER=1, STAGE=2, DONE=3.
- HOLD:
  - rstb_ch all 0. cnt increments each edge.
  - When cnt==HOLD_CYCLES-1: cnt<=0, go to FILTER.
  - porb_s and sw_rst_req are ignored; the hold time is not restarted.
- FILTER:
  - If porb_s==0, cnt<=0 and stay in FILTER. This is not a HOLD entry and is not counted as an event.
  - If porb_s==1, cnt increments. On the edge where cnt==FILTER_CYCLES-1:
    - rstb_ch[0]<=1, cnt<=0, idx<=1.
    - Next state is STAGE, or DONE if NUM_CH==1.
  - sw_rst_req is ignored.
- STAGE:
  - cnt increments. When cnt==STAGE_CYCLES-1: rstb_ch[idx]<=1, cnt<=0, idx<=idx+1.
  - If idx==NUM_CH-1 the next state is DONE, and porb_l<=1 on the same edge.
- DONE: hold all outputs. seq_busy=0, porb_l=1, por_l=0.
- Abort, evaluated in STAGE and DONE:
  - Trigger: porb_s==0 or sw_rst_req==1.
  - Action on the next edge: rstb_ch<=0, porb_l<=0, cnt<=0, idx<=0, state<=HOLD, por_events<=por_events+1 (saturating at 255).
  - Abort has priority over a release due on the same edge.
  - porb drop and sw request in the same cycle count as one event.
- Total latency from porb_in falling in STAGE/DONE to rstb_ch all-low is 3 edges.
- rstb_ch bits never glitch low except via abort or reset.
- Released bits are monotonic within a sequence: rstb_ch is always of the form 0..01..1 from the LSB.
- Reset asserted mid-sequence: on the next edge everything returns to reset values, including por_events.
- Edge numbering below: edge 1 = first rising clock edge with reset low.

Test Plan:
- Defaults, porb_in=1 throughout:
  - rstb_ch[0] rises after edge 20, [1] after 28, [2] after 36, [3] after 44.
  - porb_l=1 and por_l=0 after edge 44. seq_busy falls after edge 44.
  - seq_state goes 0 -> 1 (edge 4) -> 2 (edge 20) -> 3 (edge 44).
- Glitch filter: porb_in low for 3 cycles during FILTER after 10 good cycles -> counter restarts. Release of ch0 occurs 16 synchronised-high cycles after the glitch clears. por_events stays 0.
- Brown-out in DONE: drive porb_in low -> rstb_ch=0 and porb_l=0 exactly 3 edges later; por_events=1. Restore porb_in -> full sequence repeats with the same 4/16/8 timing.
- sw_rst_req pulse in STAGE with rstb_ch=4'b0011:
  - rstb_ch=0 after the next edge, por_events increments.
  - A sw_rst_req during HOLD/FILTER is ignored: no event, no timing change.
- Simultaneous porb drop and sw_rst_req, and abort on the same edge a release is due -> release is suppressed; por_events increments by exactly 1. Then 256 further aborts -> por_events saturates at 255.
- reset=1 mid-STAGE, then NUM_CH=1 and NUM_CH=8 builds:
  - reset mid-STAGE -> all outputs at reset values after one edge, and the sequence restarts from HOLD.
  - NUM_CH=1: porb_l rises on the same edge as rstb_ch[0], after edge 20.
  - NUM_CH=8: last release after edge 76.
